// File: rtl/ucircuit2_pkg.sv
// Shared constants for the ucircuit2 adder / recover datapath pair.
package ucircuit2_pkg;
   localparam int DATAWIDTH = 32;
   localparam int BWIDTH    = 16;
   localparam int AWIDTH    = 8;
   localparam int CNTWIDTH  = 16;
   localparam logic [AWIDTH-1:0] A_MAX = {AWIDTH{1'b1}};
endpackage

// File: rtl/ucircuit2_recover_pipe_stage.sv
// Data+valid pipeline register with load enable and async active-low reset.
module pipe_stage #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   // Capture valid and data together; hold both when not loading.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load) begin
         o_valid <= i_valid;
         o_data  <= i_data;
      end
   end

endmodule

// File: rtl/ucircuit2_recover.sv
// Recovers the 8-bit operand a = c - b from the adder sum, clamping and
// flagging values that cannot be a legal a, and counting delivered flags.
// Two-stage valid/ready pipeline: SUB stage, then COMP/clamp stage.
module ucircuit2_recover
   import ucircuit2_pkg::*;
#(
   parameter int DATAWIDTH = ucircuit2_pkg::DATAWIDTH,
   parameter int BWIDTH    = ucircuit2_pkg::BWIDTH,
   parameter int AWIDTH    = ucircuit2_pkg::AWIDTH,
   parameter int CNTWIDTH  = ucircuit2_pkg::CNTWIDTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] c,
   input  logic [BWIDTH-1:0]    b,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [AWIDTH-1:0]    a,
   output logic                 ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 clr,
   output logic [CNTWIDTH-1:0]  err_cnt
);

   // Largest legal a, widened to the difference width for the range compare.
   localparam logic [DATAWIDTH-1:0] L_A_MAX =
      {{(DATAWIDTH-AWIDTH){1'b0}}, {AWIDTH{1'b1}}};

   logic [DATAWIDTH-1:0] w_b_ext;
   logic [DATAWIDTH-1:0] w_d;
   logic                 w_brw;
   logic                 w_v1;
   logic                 w_v2;
   logic                 w_ld1;
   logic                 w_ld2;
   logic [DATAWIDTH-1:0] w_s1_d;
   logic                 w_s1_brw;
   logic [AWIDTH-1:0]    w_a;
   logic                 w_ovf;
   logic [CNTWIDTH-1:0]  r_err_cnt;

   // Stage 2 frees up when empty or drained; stage 1 when empty or moving on.
   assign w_ld2     = !w_v2 || out_ready;
   assign w_ld1     = !w_v1 || w_ld2;
   assign in_ready  = !w_v1 || !w_v2 || out_ready;
   assign out_valid = w_v2;
   assign err_cnt   = r_err_cnt;

   // SUB: modular difference plus unsigned borrow.
   assign w_b_ext = {{(DATAWIDTH-BWIDTH){1'b0}}, b};
   assign w_d     = c - w_b_ext;
   assign w_brw   = (c < w_b_ext);

   pipe_stage #(.W(DATAWIDTH + 1)) u_stage1 (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_load  (w_ld1),
      .i_valid (in_valid),
      .i_data  ({w_brw, w_d}),
      .o_valid (w_v1),
      .o_data  ({w_s1_brw, w_s1_d})
   );

   // COMP/clamp: borrow pins a to 0, oversize pins a to its maximum.
   always_comb begin
      w_a   = w_s1_d[AWIDTH-1:0];
      w_ovf = 1'b0;
      if (w_s1_brw) begin
         w_a   = '0;
         w_ovf = 1'b1;
      end else if (w_s1_d > L_A_MAX) begin
         w_a   = {AWIDTH{1'b1}};
         w_ovf = 1'b1;
      end
   end

   pipe_stage #(.W(AWIDTH + 1)) u_stage2 (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_load  (w_ld2),
      .i_valid (w_v1),
      .i_data  ({w_ovf, w_a}),
      .o_valid (w_v2),
      .o_data  ({ovf, a})
   );

   // Count delivered out-of-range results, saturating; clear wins.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_err_cnt <= '0;
      end else if (clr) begin
         r_err_cnt <= '0;
      end else if (w_v2 && out_ready && ovf && (r_err_cnt != {CNTWIDTH{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

endmodule
